irq_fetch_controller: RTL and testbench

//  Interrupt sequencer for the SimpleRISC fetch stage. Latches and masks external IRQ lines,

---
 rtl/simplerisc_irq_pkg.sv | 18 +
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_fetch_controller.sv | 96 +++++++++
 tb/tb_irq_fetch_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_irq_pkg.sv
// Shared types and constants for the SimpleRISC interrupt sequencer and fetch stage.
package simplerisc_irq_pkg;

    localparam int unsigned IRQ_ID_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ISR  = 2'd2
    } irq_state_e;

    localparam logic [31:0] DEFAULT_VEC_BASE   = 32'h0000_0100;
    localparam int unsigned DEFAULT_VEC_STRIDE = 16;

    // Instruction fetch injects on a redirect flush
    localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc
    import simplerisc_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0]  req_i,
    output logic                valid_o,
    output logic [IRQ_ID_W-1:0] sel_o
);

    // Scan high to low so the last hit (lowest index) is the one kept
    always_comb begin
        valid_o = 1'b0;
        sel_o   = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                sel_o   = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_fetch_controller.sv
// Interrupt sequencer for the fetch stage: latches/masks IRQs, picks a source,
// pulses a redirect to its vector and holds the return PC until reti.
module irq_fetch_controller
    import simplerisc_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = DEFAULT_VEC_BASE,
    parameter int unsigned VEC_STRIDE = DEFAULT_VEC_STRIDE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_wdata,
    input  logic [31:0]         pc_F,
    input  logic                isbranchtaken_E,
    input  logic                add_stall,
    input  logic                reti_E,
    output logic                interrupt,
    output logic [31:0]         pc_isr,
    output logic [31:0]         pc_ret,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic                in_isr
);

    irq_state_e            state_q, state_d;
    logic [NUM_IRQ-1:0]    pend_q, pend_d;
    logic [NUM_IRQ-1:0]    mask_q, mask_d;
    logic [31:0]           pc_ret_q, pc_ret_d;
    logic [IRQ_ID_W-1:0]   irq_id_q, irq_id_d;

    logic [NUM_IRQ-1:0]    req;
    logic                  req_valid;
    logic [IRQ_ID_W-1:0]   sel;
    logic                  take;
    logic [NUM_IRQ-1:0]    ack_vec;

    assign req = pend_q & mask_q;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req_i   (req),
        .valid_o (req_valid),
        .sel_o   (sel)
    );

    // Branch and stall both veto the take so a wrong-path or frozen PC is never saved
    assign take    = (state_q == PEND) && !isbranchtaken_E && !add_stall && req_valid;
    assign ack_vec = take ? (NUM_IRQ'(1) << sel) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            mask_q   <= '0;
            pc_ret_q <= '0;
            irq_id_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            pc_ret_q <= pc_ret_d;
            irq_id_q <= irq_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = (pend_q | irq) & ~ack_vec;
        mask_d   = mask_we ? mask_wdata : mask_q;
        pc_ret_d = take ? pc_F : pc_ret_q;
        irq_id_d = take ? sel : irq_id_q;
        unique case (state_q)
            IDLE: if (req_valid) state_d = PEND;
            PEND: begin
                if (!req_valid) state_d = IDLE;
                else if (take)  state_d = ISR;
            end
            ISR:  if (reti_E) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Redirect outputs are decoded combinationally so fetch can flush in the take cycle
    always_comb begin
        interrupt = take;
        irq_ack   = ack_vec;
        in_isr    = (state_q == ISR);
        pc_isr    = VEC_BASE + (32'(sel) * 32'(VEC_STRIDE));
        pc_ret    = pc_ret_q;
        irq_id    = irq_id_q;
    end

endmodule

// File: tb/tb_irq_fetch_controller.sv
// Directed bench for irq_fetch_controller with a queue of expected interrupt pulses.
module tb_irq_fetch_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic [31:0] pc_F;
    logic        isbranchtaken_E;
    logic        add_stall;
    logic        reti_E;
    logic        interrupt;
    logic [31:0] pc_isr;
    logic [31:0] pc_ret;
    logic [3:0]  irq_ack;
    logic [3:0]  irq_id;
    logic        in_isr;

    typedef struct {
        logic [31:0] vec;
        logic [3:0]  ack;
        logic [3:0]  id;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          n_cmp;
    int          n_err;
    logic        saw_pulse;
    logic [31:0] take_pc;
    logic [3:0]  take_id;

    irq_fetch_controller #(
        .NUM_IRQ    (4),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .irq             (irq),
        .mask_we         (mask_we),
        .mask_wdata      (mask_wdata),
        .pc_F            (pc_F),
        .isbranchtaken_E (isbranchtaken_E),
        .add_stall       (add_stall),
        .reti_E          (reti_E),
        .interrupt       (interrupt),
        .pc_isr          (pc_isr),
        .pc_ret          (pc_ret),
        .irq_ack         (irq_ack),
        .irq_id          (irq_id),
        .in_isr          (in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs against the scoreboard mid-cycle, then advance
    task automatic tick();
        #1;
        saw_pulse = interrupt;
        if (interrupt === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                chk("pc_isr", pc_isr, cur.vec);
                chk("irq_ack", 32'(irq_ack), 32'(cur.ack));
                take_id = cur.id;
            end
            take_pc = pc_F;
        end else begin
            chk("ack_idle", 32'(irq_ack), 32'd0);
        end
        @(negedge clk);
        pc_F = pc_F + 32'd4;
    endtask

    task automatic push(input logic [31:0] vec, input logic [3:0] ack, input logic [3:0] id);
        exp_t e;
        e.vec = vec;
        e.ack = ack;
        e.id  = id;
        sb.push_back(e);
    endtask

    task automatic expect_pulse_within(input string tag, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = saw_pulse;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic check_isr();
        #1;
        chk("in_isr_after_take", 32'(in_isr), 32'd1);
        chk("pc_ret", pc_ret, take_pc);
        chk("irq_id", 32'(irq_id), 32'(take_id));
    endtask

    task automatic do_reti();
        reti_E = 1'b1;
        tick();
        reti_E = 1'b0;
        #1;
        chk("in_isr_after_reti", 32'(in_isr), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        take_pc = '0;
        take_id = '0;
        rst = 1'b1;
        irq = '0;
        mask_we = 1'b0;
        mask_wdata = '0;
        pc_F = 32'h0000_2000;
        isbranchtaken_E = 1'b0;
        add_stall = 1'b0;
        reti_E = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_in_isr", 32'(in_isr), 32'd0);
        chk("rst_pc_isr", pc_isr, 32'h100);
        chk("rst_pc_ret", pc_ret, 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);

        // 1: single pulse on irq[2]
        mask_we = 1'b1; mask_wdata = 4'b1111; tick(); mask_we = 1'b0;
        irq = 4'b0100; tick(); irq = 4'b0000;
        push(32'h120, 4'b0100, 4'd2);
        tick(); chk("t1_no_early", 32'(saw_pulse), 32'd0);
        tick(); chk("t1_pulse", 32'(saw_pulse), 32'd1);
        check_isr();
        do_reti();

        // 2: simultaneous irq[1] and irq[3]
        irq = 4'b1010; tick(); irq = 4'b0000;
        push(32'h110, 4'b0010, 4'd1);
        push(32'h130, 4'b1000, 4'd3);
        expect_pulse_within("t2_first", 4);
        check_isr();
        do_reti();
        tick(); chk("t2_idle_gap", 32'(saw_pulse), 32'd0);
        tick(); chk("t2_second", 32'(saw_pulse), 32'd1);
        check_isr();
        do_reti();

        // 3: branch then two stalls hold off the take
        irq = 4'b0001; tick(); irq = 4'b0000;
        tick(); chk("t3_idle", 32'(saw_pulse), 32'd0);
        isbranchtaken_E = 1'b1; tick(); chk("t3_branch", 32'(saw_pulse), 32'd0);
        isbranchtaken_E = 1'b0; add_stall = 1'b1;
        tick(); chk("t3_stall1", 32'(saw_pulse), 32'd0);
        tick(); chk("t3_stall2", 32'(saw_pulse), 32'd0);
        add_stall = 1'b0;
        push(32'h100, 4'b0001, 4'd0);
        tick(); chk("t3_pulse", 32'(saw_pulse), 32'd1);
        check_isr();
        do_reti();

        // 4: masked request waits for a mask write
        mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
        irq = 4'b0001; tick(); irq = 4'b0000;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (saw_pulse) pulses++;
            end
            chk("t4_masked", 32'(pulses), 32'd0);
        end
        mask_we = 1'b1; mask_wdata = 4'b0001; tick(); mask_we = 1'b0;
        chk("t4_write_cycle", 32'(saw_pulse), 32'd0);
        push(32'h100, 4'b0001, 4'd0);
        tick(); chk("t4_w1", 32'(saw_pulse), 32'd0);
        tick(); chk("t4_w2", 32'(saw_pulse), 32'd1);
        check_isr();
        do_reti();
        mask_we = 1'b1; mask_wdata = 4'b1111; tick(); mask_we = 1'b0;

        // 5: request during ISR waits for reti plus one idle cycle
        irq = 4'b0100; tick(); irq = 4'b0000;
        push(32'h120, 4'b0100, 4'd2);
        expect_pulse_within("t5_enter", 4);
        irq = 4'b0001; tick(); irq = 4'b0000;
        chk("t5_no_nest0", 32'(saw_pulse), 32'd0);
        tick(); chk("t5_no_nest1", 32'(saw_pulse), 32'd0);
        tick(); chk("t5_no_nest2", 32'(saw_pulse), 32'd0);
        do_reti();
        chk("t5_reti_cycle", 32'(saw_pulse), 32'd0);
        push(32'h100, 4'b0001, 4'd0);
        tick(); chk("t5_idle_gap", 32'(saw_pulse), 32'd0);
        tick(); chk("t5_pulse", 32'(saw_pulse), 32'd1);
        check_isr();
        do_reti();

        // 6: reset mid-ISR discards everything
        irq = 4'b0010; tick(); irq = 4'b0000;
        push(32'h110, 4'b0010, 4'd1);
        expect_pulse_within("t6_enter", 4);
        irq = 4'b1000; tick(); irq = 4'b0000;
        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        chk("t6_in_isr", 32'(in_isr), 32'd0);
        chk("t6_pc_ret", pc_ret, 32'd0);
        chk("t6_irq_id", 32'(irq_id), 32'd0);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (saw_pulse) pulses++;
            end
            mask_we = 1'b1; mask_wdata = 4'b1111; tick(); mask_we = 1'b0;
            if (saw_pulse) pulses++;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (saw_pulse) pulses++;
            end
            chk("t6_pend_cleared", 32'(pulses), 32'd0);
        end
        chk("t6_in_isr_late", 32'(in_isr), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
